// File: rtl/sram_req_arbiter.sv
// Two-requester (inst/data) sram-like arbiter with an in-order owner FIFO that routes responses back.
// Optional feature macro: ARB_RR_EN selects round-robin arbitration; when undefined, data has fixed priority.
module sram_req_arbiter #(
    parameter  int unsigned OUTST_DEPTH = 4,
    parameter  int unsigned CMD_W       = 71,
    localparam int unsigned CNT_W       = $clog2(OUTST_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inst_req,
    input  logic [CMD_W-1:0] inst_cmd,
    output logic             inst_addr_ok,
    output logic             inst_data_ok,
    output logic [31:0]      inst_rdata,
    input  logic             data_req,
    input  logic [CMD_W-1:0] data_cmd,
    output logic             data_addr_ok,
    output logic             data_data_ok,
    output logic [31:0]      data_rdata,
    output logic             m_req,
    output logic [CMD_W-1:0] m_cmd,
    input  logic             m_addr_ok,
    input  logic             m_data_ok,
    input  logic [31:0]      m_rdata,
    output logic [CNT_W-1:0] outst_cnt
);

    localparam int unsigned PTR_W = $clog2(OUTST_DEPTH);

    typedef enum logic {
        S_OPEN   = 1'b0,
        S_LOCKED = 1'b1
    } lock_state_e;

    lock_state_e            r_state;
    lock_state_e            w_state_nxt;
    logic                   r_lock_owner;
    logic                   w_lock_owner_nxt;
    logic [OUTST_DEPTH-1:0] r_owner;
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [CNT_W-1:0]       r_cnt;

    logic w_full;
    logic w_empty;
    logic w_pri;
    logic w_grant;
    logic w_push;
    logic w_pop;
    logic w_head;

    assign w_full  = (r_cnt == CNT_W'(OUTST_DEPTH));
    assign w_empty = (r_cnt == CNT_W'(0));

`ifdef ARB_RR_EN
    logic r_rr_pri;

    // Priority passes to the requester that did not win the last accepted push.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_pri <= 1'b0;
        end else if (w_push) begin
            r_rr_pri <= ~w_grant;
        end
    end

    assign w_pri = r_rr_pri;
`else
    assign w_pri = 1'b1;
`endif

    // Grant: 0 = inst, 1 = data; a stalled request keeps its owner until accepted.
    always_comb begin
        w_grant = data_req;
        if (r_state == S_LOCKED) begin
            w_grant = r_lock_owner;
        end else if (inst_req && data_req) begin
            w_grant = w_pri;
        end
    end

    assign m_req  = (inst_req | data_req) & ~w_full & ~reset;
    assign m_cmd  = reset ? '0 : (w_grant ? data_cmd : inst_cmd);
    assign w_push = m_req & m_addr_ok;
    assign w_pop  = m_data_ok & ~w_empty & ~reset;
    assign w_head = r_owner[r_rd_ptr];

    assign inst_addr_ok = w_push & ~w_grant;
    assign data_addr_ok = w_push & w_grant;
    assign inst_data_ok = w_pop & ~w_head;
    assign data_data_ok = w_pop & w_head;
    assign inst_rdata   = reset ? 32'h0 : m_rdata;
    assign data_rdata   = reset ? 32'h0 : m_rdata;
    assign outst_cnt    = reset ? '0 : r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_OPEN;
            r_lock_owner <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_lock_owner <= w_lock_owner_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_lock_owner_nxt = r_lock_owner;
        if (m_req) begin
            if (m_addr_ok) begin
                w_state_nxt = S_OPEN;
            end else begin
                w_state_nxt      = S_LOCKED;
                w_lock_owner_nxt = w_grant;
            end
        end
    end

    // In-order owner FIFO; pointers wrap naturally since depth is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_owner[r_wr_ptr] <= w_grant;
                r_wr_ptr          <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed self-checking bench for sram_req_arbiter (expectations follow ARB_RR_EN when defined).
module tb_sram_req_arbiter;

    localparam int unsigned CMD_W = 71;
    localparam int unsigned CNT_W = 3;

    logic             clk;
    logic             reset;
    logic             inst_req;
    logic [CMD_W-1:0] inst_cmd;
    logic             inst_addr_ok;
    logic             inst_data_ok;
    logic [31:0]      inst_rdata;
    logic             data_req;
    logic [CMD_W-1:0] data_cmd;
    logic             data_addr_ok;
    logic             data_data_ok;
    logic [31:0]      data_rdata;
    logic             m_req;
    logic [CMD_W-1:0] m_cmd;
    logic             m_addr_ok;
    logic             m_data_ok;
    logic [31:0]      m_rdata;
    logic [CNT_W-1:0] outst_cnt;

    int checks;
    int errors;

    sram_req_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .inst_req     (inst_req),
        .inst_cmd     (inst_cmd),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_cmd     (data_cmd),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .m_req        (m_req),
        .m_cmd        (m_cmd),
        .m_addr_ok    (m_addr_ok),
        .m_data_ok    (m_data_ok),
        .m_rdata      (m_rdata),
        .outst_cnt    (outst_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        inst_req  = 1'b0;
        data_req  = 1'b0;
        m_addr_ok = 1'b0;
        m_data_ok = 1'b0;
        m_rdata   = 32'h0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        inst_req  = 1'b1;
        data_req  = 1'b1;
        m_addr_ok = 1'b1;
        m_data_ok = 1'b1;
        m_rdata   = 32'hFFFF_FFFF;
        #1;
        checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL rst_m_req got %0h exp 0", m_req); end
        checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b00) begin errors++; $display("FAIL rst_addr_ok got %0b exp 00", {inst_addr_ok, data_addr_ok}); end
        checks++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin errors++; $display("FAIL rst_data_ok got %0b exp 00", {inst_data_ok, data_data_ok}); end
        tick();
        tick();
        reset = 1'b0;
        idle_inputs();
        tick();
        checks++; if (outst_cnt !== 3'd0) begin errors++; $display("FAIL rst_cnt got %0d exp 0", outst_cnt); end
    endtask

    // Both requesters contend; fixed priority picks data, round-robin alternates starting with inst.
    task automatic test_priority();
        logic [CMD_W-1:0] ic;
        logic [CMD_W-1:0] dc;
        logic             exp_own [4];
        ic = {1'b0, 2'b10, 4'hF, 32'h1000_0000, 32'h0000_0000};
        dc = {1'b1, 2'b10, 4'hF, 32'h2000_0000, 32'hDEAD_BEEF};
        inst_cmd  = ic;
        data_cmd  = dc;
        inst_req  = 1'b1;
        data_req  = 1'b1;
        m_addr_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
`ifdef ARB_RR_EN
            exp_own[i] = 1'(i % 2);
`else
            exp_own[i] = 1'b1;
`endif
            #1;
            checks++; if (data_addr_ok !== exp_own[i]) begin errors++; $display("FAIL prio_data_addr_ok[%0d] got %0b exp %0b", i, data_addr_ok, exp_own[i]); end
            checks++; if (inst_addr_ok !== ~exp_own[i]) begin errors++; $display("FAIL prio_inst_addr_ok[%0d] got %0b exp %0b", i, inst_addr_ok, ~exp_own[i]); end
            checks++; if (m_cmd !== (exp_own[i] ? dc : ic)) begin errors++; $display("FAIL prio_m_cmd[%0d] got %0h exp %0h", i, m_cmd, (exp_own[i] ? dc : ic)); end
            tick();
        end
        checks++; if (outst_cnt !== 3'd4) begin errors++; $display("FAIL prio_cnt got %0d exp 4", outst_cnt); end
        checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL prio_full_m_req got %0b exp 0", m_req); end
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            m_data_ok = 1'b1;
            m_rdata   = 32'hA0 + 32'(i);
            #1;
            checks++; if (data_data_ok !== exp_own[i] || inst_data_ok !== ~exp_own[i]) begin
                errors++; $display("FAIL prio_drain[%0d] got i=%0b d=%0b exp d=%0b", i, inst_data_ok, data_data_ok, exp_own[i]);
            end
            tick();
        end
        idle_inputs();
        checks++; if (outst_cnt !== 3'd0) begin errors++; $display("FAIL prio_drain_cnt got %0d exp 0", outst_cnt); end
    endtask

    // Owners inst, data, inst must route responses back in request order.
    task automatic test_routing();
        logic [2:0]  own;
        logic [31:0] rd [3];
        own = 3'b010;
        rd[0] = 32'h11; rd[1] = 32'h22; rd[2] = 32'h33;
        for (int i = 0; i < 3; i++) begin
            inst_req  = ~own[i];
            data_req  = own[i];
            m_addr_ok = 1'b1;
            #1;
            checks++; if ({data_addr_ok, inst_addr_ok} !== {own[i], ~own[i]}) begin
                errors++; $display("FAIL route_push[%0d] got d=%0b i=%0b exp d=%0b", i, data_addr_ok, inst_addr_ok, own[i]);
            end
            tick();
        end
        idle_inputs();
        checks++; if (outst_cnt !== 3'd3) begin errors++; $display("FAIL route_cnt3 got %0d exp 3", outst_cnt); end
        for (int i = 0; i < 3; i++) begin
            m_data_ok = 1'b1;
            m_rdata   = rd[i];
            #1;
            checks++; if ({data_data_ok, inst_data_ok} !== {own[i], ~own[i]}) begin
                errors++; $display("FAIL route_pop[%0d] got d=%0b i=%0b exp d=%0b", i, data_data_ok, inst_data_ok, own[i]);
            end
            checks++; if ((own[i] ? data_rdata : inst_rdata) !== rd[i]) begin
                errors++; $display("FAIL route_rdata[%0d] got %0h exp %0h", i, (own[i] ? data_rdata : inst_rdata), rd[i]);
            end
            tick();
        end
        idle_inputs();
        checks++; if (outst_cnt !== 3'd0) begin errors++; $display("FAIL route_cnt0 got %0d exp 0", outst_cnt); end
    endtask

    // A stalled inst request keeps the grant although data starts requesting.
    task automatic test_lock();
        logic [CMD_W-1:0] ic;
        logic [CMD_W-1:0] dc;
        ic = {1'b0, 2'b01, 4'h3, 32'h0000_4000, 32'h0};
        dc = {1'b1, 2'b00, 4'h1, 32'h0000_8000, 32'h5A};
        inst_cmd = ic;
        data_cmd = dc;
        inst_req = 1'b1;
        for (int c = 0; c < 3; c++) begin
            data_req = (c >= 1);
            #1;
            checks++; if (m_req !== 1'b1 || m_cmd !== ic) begin errors++; $display("FAIL lock_cmd[%0d] got req=%0b cmd=%0h exp req=1 cmd=%0h", c, m_req, m_cmd, ic); end
            checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b00) begin errors++; $display("FAIL lock_wait_ok[%0d] got %0b exp 00", c, {inst_addr_ok, data_addr_ok}); end
            tick();
        end
        m_addr_ok = 1'b1;
        #1;
        checks++; if (inst_addr_ok !== 1'b1 || data_addr_ok !== 1'b0 || m_cmd !== ic) begin
            errors++; $display("FAIL lock_accept got i=%0b d=%0b cmd=%0h exp i=1 d=0 cmd=%0h", inst_addr_ok, data_addr_ok, m_cmd, ic);
        end
        tick();
        inst_req = 1'b0;
        #1;
        checks++; if (data_addr_ok !== 1'b1 || m_cmd !== dc) begin errors++; $display("FAIL lock_next got d=%0b cmd=%0h exp d=1 cmd=%0h", data_addr_ok, m_cmd, dc); end
        tick();
        idle_inputs();
        m_data_ok = 1'b1;
        #1;
        checks++; if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0) begin errors++; $display("FAIL lock_pop0 got i=%0b d=%0b exp i=1 d=0", inst_data_ok, data_data_ok); end
        tick();
        #1;
        checks++; if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b1) begin errors++; $display("FAIL lock_pop1 got i=%0b d=%0b exp i=0 d=1", inst_data_ok, data_data_ok); end
        tick();
        idle_inputs();
        checks++; if (outst_cnt !== 3'd0) begin errors++; $display("FAIL lock_cnt got %0d exp 0", outst_cnt); end
    endtask

    // Full blocks the request even with a same-cycle pop; then wrap pointers with push+pop pairs.
    task automatic test_full_wrap();
        logic o;
        logic po;
        inst_req  = 1'b1;
        m_addr_ok = 1'b1;
        repeat (4) tick();
        checks++; if (outst_cnt !== 3'd4) begin errors++; $display("FAIL full_cnt4 got %0d exp 4", outst_cnt); end
        m_data_ok = 1'b1;
        #1;
        checks++; if (m_req !== 1'b0 || inst_data_ok !== 1'b1) begin errors++; $display("FAIL full_pop got req=%0b dok=%0b exp req=0 dok=1", m_req, inst_data_ok); end
        tick();
        checks++; if (outst_cnt !== 3'd3) begin errors++; $display("FAIL full_cnt3 got %0d exp 3", outst_cnt); end
        m_data_ok = 1'b0;
        #1;
        checks++; if (m_req !== 1'b1 || inst_addr_ok !== 1'b1) begin errors++; $display("FAIL full_refill got req=%0b aok=%0b exp 1 1", m_req, inst_addr_ok); end
        tick();
        checks++; if (outst_cnt !== 3'd4) begin errors++; $display("FAIL full_cnt4b got %0d exp 4", outst_cnt); end
        idle_inputs();
        m_data_ok = 1'b1;
        repeat (4) tick();
        idle_inputs();
        po = 1'b0;
        for (int i = 0; i < 9; i++) begin
            o         = 1'(i % 2);
            inst_req  = ~o;
            data_req  = o;
            m_addr_ok = 1'b1;
            m_data_ok = (i > 0);
            #1;
            checks++; if (m_req !== 1'b1) begin errors++; $display("FAIL wrap_req[%0d] got %0b exp 1", i, m_req); end
            if (i > 0) begin
                checks++; if ({data_data_ok, inst_data_ok} !== {po, ~po}) begin
                    errors++; $display("FAIL wrap_pop[%0d] got d=%0b i=%0b exp d=%0b", i, data_data_ok, inst_data_ok, po);
                end
            end
            po = o;
            tick();
        end
        idle_inputs();
        checks++; if (outst_cnt !== 3'd1) begin errors++; $display("FAIL wrap_cnt got %0d exp 1", outst_cnt); end
        m_data_ok = 1'b1;
        #1;
        checks++; if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0) begin errors++; $display("FAIL wrap_last got i=%0b d=%0b exp i=1 d=0", inst_data_ok, data_data_ok); end
        tick();
        idle_inputs();
        checks++; if (outst_cnt !== 3'd0) begin errors++; $display("FAIL wrap_cnt0 got %0d exp 0", outst_cnt); end
    endtask

    // Stray responses while empty and stray acceptances with no request are ignored.
    task automatic test_protocol_errors();
        m_data_ok = 1'b1;
        m_rdata   = 32'h77;
        #1;
        checks++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin errors++; $display("FAIL empty_pop got %0b exp 00", {inst_data_ok, data_data_ok}); end
        tick();
        checks++; if (outst_cnt !== 3'd0) begin errors++; $display("FAIL empty_cnt got %0d exp 0", outst_cnt); end
        idle_inputs();
        m_addr_ok = 1'b1;
        #1;
        checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b00) begin errors++; $display("FAIL stray_aok got %0b exp 00", {inst_addr_ok, data_addr_ok}); end
        tick();
        idle_inputs();
        checks++; if (outst_cnt !== 3'd0) begin errors++; $display("FAIL stray_cnt got %0d exp 0", outst_cnt); end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        inst_cmd = '0;
        data_cmd = '0;
        idle_inputs();
        @(posedge clk);
        #1;
        test_reset();
        test_priority();
        test_routing();
        test_lock();
        test_full_wrap();
        test_protocol_errors();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
